debug_slave_mc_sysclk: RTL
==========================

# debug_slave_mc_sysclk

Parametrised, multi-channel successor to the single-CPU debug-slave system-clock logic. It receives a scan-chain protocol already in the `clk` domain: strobes `cdr`/`sdr`/`udr`/`uir`, serial `tdi`/`tdo`, and the instruction register. It shifts a `DR_W`-bit data register, captures readback from one of `N_CH` worker CPUs, and issues completed update commands to the selected CPU over a per-channel valid/ready handshake, with overrun detection. It sits between the shared JTAG virtual-node glue and the `N_CH` worker CPU debug modules.

## Interface
Parameters:
- `N_CH`, default 4: number of worker CPU channels (1..16).
- `DR_W`, default 38: data-register width. Equals the `jdo` width.
- `IR_W`, default 2: instruction-register width.
- `CH_W`, derived as max(1, $clog2(N_CH)), local: channel-select width.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ir_in`  in  IR_W: instruction value, sampled on `uir`.
- `ch_sel`  in  CH_W: target channel, sampled on `uir`.
- `uir`  in  1: update-IR strobe, one cycle.
- `cdr`  in  1: capture-DR strobe, one cycle.
- `sdr`  in  1: shift-DR enable; one bit per asserted cycle.
- `udr`  in  1: update-DR strobe, one cycle.
- `tdi`  in  1: serial data in.
- `tdo`  out  1: serial data out, equal to `sr[0]`.
- `rd_data`  in  N_CH*DR_W: per-channel capture data; channel k occupies `[k*DR_W +: DR_W]`.
- `cmd_valid`  out  N_CH: one-hot command-valid bit per channel.
- `cmd_ready`  in  N_CH: per-channel accept.
- `cmd_ir`  out  IR_W: instruction of the pending command.
- `jdo`  out  DR_W: data of the pending command.
- `busy`  out  1: OR of all `cmd_valid` bits.
- `overrun`  out  1: sticky flag; a `udr` was dropped.
- `ch_err`  out  1: sticky flag; `ch_sel` >= N_CH was latched.

## Operation
- On `uir`:
  - `ir_q` <= `ir_in`; `ch_q` <= `ch_sel`.
  - `ch_err` <= (`ch_sel` >= N_CH).
  - `overrun` <= 0.
- On `cdr`:
  - `sr` <= the `rd_data` slice for `ch_q`.
  - If `ch_q` is invalid, `sr` <= 0.
- On `sdr` without `cdr`: `sr` <= {`tdi`, `sr[DR_W-1:1]`}, i.e. LSB shifts out first.
- `cdr` and `sdr` in the same cycle: `cdr` wins; no shift that cycle.
- Command FSM, two states:
  - IDLE: `cmd_valid` == 0.
  - PEND: exactly one `cmd_valid` bit set.
- Transitions:
  - IDLE→PEND on `udr` with a valid `ch_q`. Load `jdo` <= `sr`, `cmd_ir` <= `ir_q`, `cmd_valid` <= onehot(`ch_q`).
  - PEND→IDLE when `cmd_valid[k]` & `cmd_ready[k]` for the active channel k.
- `udr` while in PEND with no handshake completing that cycle: command dropped, `overrun` <= 1, and `jdo`/`cmd_ir`/`cmd_valid` unchanged.
- `udr` in the same cycle as handshake completion: accepted, no overrun. The new command loads directly (PEND→PEND) for the new channel.
- `udr` with an invalid `ch_q`: ignored. No command, and `overrun` is unchanged.
- `cmd_ready` on non-selected channels: ignored.
- `jdo`, `cmd_ir` and `cmd_valid` are stable while in PEND.
- `uir` and `udr` in the same cycle: `udr` uses the pre-update `ir_q`/`ch_q`.

## Timing
- Reset values: `sr`, `ir_q`, `ch_q`, `jdo`, `cmd_ir`, `cmd_valid`, `overrun` and `ch_err` are all 0. Consequently `tdo`=0 and `busy`=0.
- `udr` in cycle t → `cmd_valid` high in cycle t+1. The minimum command occupancy is 1 cycle, when `cmd_ready` is already high.
- Capture: `cdr` in cycle t → `tdo` = captured bit 0 in t+1. Each subsequent `sdr` cycle advances `tdo` by one bit.
- `reset` asserted mid-command or mid-shift: everything returns to reset values on the next edge. The pending command is discarded without a handshake.
- All outputs are registered except `tdo` (a direct bit of `sr`) and `busy` (an OR of registers).

## Structure
- Package `debug_slave_pkg`:
  - IR encodings: `IR_OCIMEM`=0, `IR_TRACEMEM`=1, `IR_BREAK`=2, `IR_TRACECTRL`=3.
  - Default constants `DEBUG_DR_W`=38 and `DEBUG_IR_W`=2.
  - Command FSM state enum {IDLE, PEND}.
- One sub-module, `debug_slave_scan_reg`, holds the `sr` capture/shift register and the `rd_data` mux. The top level holds the IR/channel latch, the command FSM and the flags.

## Test plan
- Reset, then capture/shift with N_CH=4:
  - Stimulus: `uir` with `ch_sel`=2, then `cdr` with `rd_data` slice 2 = 38'h2_ABCD_1234, then 38 `sdr` cycles.
  - Required response: `tdo` emits 0x2ABCD1234 LSB first.
- Update and handshake:
  - Stimulus: shift in 38'h15, `ir_in`=2, `ch_sel`=1, then `udr`; hold `cmd_ready[1]`=0 for 3 cycles, then 1.
  - Required response: `cmd_valid`=4'b0010 from t+1 through the ready cycle; `jdo`=38'h15, `cmd_ir`=2; IDLE on the next cycle.
- Overrun:
  - Stimulus: a second `udr` while channel 1 is stalled.
  - Required response: `overrun`=1 and `jdo` still 38'h15. The next `uir` clears `overrun`.
- Back-to-back:
  - Stimulus: `udr` in the same cycle as `cmd_ready[1]` completes, with `ch_q`=3.
  - Required response: `cmd_valid`=4'b1000 next cycle, `overrun`=0.
- Invalid channel:
  - Stimulus: N_CH=3, `ch_sel`=3, then `cdr` and `udr`.
  - Required response: `ch_err`=1, captured `sr`=0, no `cmd_valid`.
- Reset mid-command:
  - Stimulus: `reset` asserted while in PEND.
  - Required response: `cmd_valid`=0, `jdo`=0, `busy`=0 on the next edge.

Source files
------------

// File: rtl/debug_slave_pkg.sv
// Shared definitions for the multi-channel debug slave.
// Holds the instruction encodings, default register widths, the command
// FSM state type and a small channel range helper used by the top level.
package debug_slave_pkg;

  localparam int DEBUG_DR_W = 38;
  localparam int DEBUG_IR_W = 2;

  localparam logic [DEBUG_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEBUG_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEBUG_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEBUG_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } cmd_state_t;

  // True when a latched channel number addresses an existing worker CPU.
  function automatic logic ch_in_range(input int unsigned ch, input int unsigned n_ch);
    return ch < n_ch;
  endfunction

endpackage

// File: rtl/debug_slave_scan_reg.sv
// Capture/shift data register of the debug slave.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   cdr           - capture strobe: load the readback slice of channel ch
//   sdr           - shift enable: one bit per cycle, LSB out first
//   tdi           - serial input entering at the MSB
//   ch            - latched channel select used for the readback mux
//   rd_data       - concatenated per-channel readback, channel k at [k*DR_W +: DR_W]
//   sr            - current register contents (bit 0 drives tdo)
module debug_slave_scan_reg #(
  parameter int N_CH = 4,
  parameter int DR_W = 38,
  parameter int CH_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cdr,
  input  logic              sdr,
  input  logic              tdi,
  input  logic [CH_W-1:0]   ch,
  input  logic [N_CH*DR_W-1:0] rd_data,
  output logic [DR_W-1:0]   sr
);

  logic [DR_W-1:0] cap;

  // Readback mux; a channel number beyond N_CH matches no slice and yields zero.
  always_comb begin
    cap = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (32'(ch) == k) cap = rd_data[k*DR_W +: DR_W];
    end
  end

  // Capture takes priority over shift when both strobes coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (cdr) begin
      sr <= cap;
    end else if (sdr) begin
      sr <= {tdi, sr[DR_W-1:1]};
    end
  end

endmodule

// File: rtl/debug_slave_mc_sysclk.sv
// Multi-channel debug slave, system-clock side.
// Latches instruction and target channel on uir, shifts a DR_W-bit data
// register, and hands completed update-DR commands to one of N_CH worker
// CPUs over a valid/ready handshake, flagging dropped updates.
// Ports:
//   clk, reset           - system clock, synchronous active-high reset
//   ir_in, ch_sel, uir   - instruction and target channel, sampled on uir
//   cdr, sdr, udr, tdi   - capture / shift / update strobes, serial input
//   tdo                  - serial output (sr[0])
//   rd_data              - per-channel readback data
//   cmd_valid, cmd_ready - one-hot per-channel command handshake
//   cmd_ir, jdo          - instruction and data of the pending command
//   busy                 - a command is pending
//   overrun              - sticky: an update arrived while a command was stalled
//   ch_err               - sticky: the latched channel select was out of range
module debug_slave_mc_sysclk
  import debug_slave_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int DR_W = DEBUG_DR_W,
  parameter  int IR_W = DEBUG_IR_W,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      ir_in,
  input  logic [CH_W-1:0]      ch_sel,
  input  logic                 uir,
  input  logic                 cdr,
  input  logic                 sdr,
  input  logic                 udr,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [N_CH*DR_W-1:0] rd_data,
  output logic [N_CH-1:0]      cmd_valid,
  input  logic [N_CH-1:0]      cmd_ready,
  output logic [IR_W-1:0]      cmd_ir,
  output logic [DR_W-1:0]      jdo,
  output logic                 busy,
  output logic                 overrun,
  output logic                 ch_err
);

  logic [IR_W-1:0] ir_q;
  logic [CH_W-1:0] ch_q;
  logic [DR_W-1:0] sr;
  cmd_state_t      state;
  logic            ch_ok;
  logic            handshake;
  logic            accept;
  logic [N_CH-1:0] onehot;

  debug_slave_scan_reg #(
    .N_CH (N_CH),
    .DR_W (DR_W),
    .CH_W (CH_W)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .cdr     (cdr),
    .sdr     (sdr),
    .tdi     (tdi),
    .ch      (ch_q),
    .rd_data (rd_data),
    .sr      (sr)
  );

  assign ch_ok     = ch_in_range(32'(ch_q), N_CH);
  assign handshake = (state == PEND) && |(cmd_valid & cmd_ready);
  assign accept    = udr && ch_ok;
  assign tdo       = sr[0];
  assign busy      = |cmd_valid;

  always_comb begin
    onehot = '0;
    for (int k = 0; k < N_CH; k++) begin
      onehot[k] = (32'(ch_q) == k);
    end
  end

  // IR/channel latch, command FSM and flags. The udr path reads the
  // pre-update ir_q/ch_q, and a drop in the same cycle as uir leaves
  // overrun set because that assignment comes last.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      ch_q      <= '0;
      ch_err    <= 1'b0;
      overrun   <= 1'b0;
      state     <= IDLE;
      cmd_valid <= '0;
      cmd_ir    <= '0;
      jdo       <= '0;
    end else begin
      if (uir) begin
        ir_q    <= ir_in;
        ch_q    <= ch_sel;
        ch_err  <= !ch_in_range(32'(ch_sel), N_CH);
        overrun <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            jdo       <= sr;
            cmd_ir    <= ir_q;
            cmd_valid <= onehot;
            state     <= PEND;
          end
        end
        PEND: begin
          if (handshake) begin
            if (accept) begin
              jdo       <= sr;
              cmd_ir    <= ir_q;
              cmd_valid <= onehot;
            end else begin
              cmd_valid <= '0;
              state     <= IDLE;
            end
          end else if (accept) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          cmd_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
